// File: rtl/free_list_alloc.sv
// Free-block pool: circular FIFO of block indices, round-robin grants (0-cycle, one per cycle), one free per cycle.
// No backpressure on frees; a free into a full pool or during init is dropped and latched in err_o.
module free_list_alloc #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BLOCKS = 256,
  parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] alloc_req_i,
  output logic [NUM_PORTS-1:0] alloc_gnt_o,
  output logic [ADDR_W-1:0]    alloc_block_idx_o,
  input  logic                 free_valid_i,
  input  logic [ADDR_W-1:0]    free_idx_i,
  output logic [ADDR_W:0]      free_cnt_o,
  output logic                 empty_o,
  output logic                 init_done_o,
  output logic                 err_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(NUM_BLOCKS);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   mem [NUM_BLOCKS];

  logic                gnt_vld;
  logic [PW-1:0]       gnt_port;
  logic                free_ok;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wdat;
  int                  p;

  // Grant depends only on registered state and the live request vector.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = '0;
    p        = 0;
    if (state_q == S_RUN && cnt_q != '0) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        p = int'(rr_ptr_q) + i;
        if (p >= NUM_PORTS) p = p - NUM_PORTS;
        if (!gnt_vld && alloc_req_i[p]) begin
          gnt_vld  = 1'b1;
          gnt_port = PW'(p);
        end
      end
    end
  end

  assign alloc_gnt_o       = gnt_vld ? (NUM_PORTS'(1) << gnt_port) : '0;
  assign alloc_block_idx_o = gnt_vld ? mem[rd_ptr_q] : '0;
  assign free_cnt_o        = cnt_q;
  assign empty_o           = (cnt_q == '0);
  assign init_done_o       = (state_q == S_RUN);
  assign err_o             = err_q;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    free_ok  = 1'b0;
    mem_we   = 1'b0;
    mem_wdat = wr_ptr_q;
    case (state_q)
      S_INIT: begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == FULL - 1'b1) state_d = S_RUN;
        if (free_valid_i) err_d = 1'b1;
      end
      S_RUN: begin
        free_ok = free_valid_i && (cnt_q != FULL);
        if (free_valid_i && !free_ok) err_d = 1'b1;
        if (free_ok) begin
          mem_we   = 1'b1;
          mem_wdat = free_idx_i;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (gnt_vld) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          rr_ptr_d = (gnt_port == PW'(NUM_PORTS - 1)) ? '0 : gnt_port + 1'b1;
        end
        cnt_d = cnt_q + {{ADDR_W{1'b0}}, free_ok} - {{ADDR_W{1'b0}}, gnt_vld};
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Contents need no reset: INIT rewrites every entry before the first grant.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= mem_wdat;
  end

endmodule

// File: tb/tb_free_list_alloc.sv
// Directed bench for free_list_alloc: init, round-robin, exhaust/refill, simultaneous, errors, reset.
module tb_free_list_alloc;

  localparam int NP = 4;
  localparam int NB = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] alloc_req_i = '0;
  logic [NP-1:0] alloc_gnt_o;
  logic [AW-1:0] alloc_block_idx_o;
  logic          free_valid_i = 1'b0;
  logic [AW-1:0] free_idx_i = '0;
  logic [AW:0]   free_cnt_o;
  logic          empty_o;
  logic          init_done_o;
  logic          err_o;

  int n_chk  = 0;
  int n_fail = 0;

  free_list_alloc #(.NUM_PORTS(NP), .NUM_BLOCKS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o),
    .alloc_block_idx_o(alloc_block_idx_o),
    .free_valid_i(free_valid_i), .free_idx_i(free_idx_i),
    .free_cnt_o(free_cnt_o), .empty_o(empty_o),
    .init_done_o(init_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] req;
    logic          fv;
    logic [AW-1:0] fidx;
    logic [NP-1:0] gnt;
    logic [AW-1:0] idx;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 2 ns later, well clear of the rising edge.
  task automatic cyc(input logic [NP-1:0] req, input logic fv, input logic [AW-1:0] fidx);
    @(negedge clk);
    alloc_req_i  = req;
    free_valid_i = fv;
    free_idx_i   = fidx;
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},  int'(alloc_gnt_o), 0);
    chk({tag, "_idx"},  int'(alloc_block_idx_o), 0);
    chk({tag, "_cnt"},  int'(free_cnt_o), 0);
    chk({tag, "_empty"}, int'(empty_o), 1);
    chk({tag, "_init"}, int'(init_done_o), 0);
    chk({tag, "_err"},  int'(err_o), 0);
  endtask

  initial begin
    int exp_idx;
    vec[0]  = '{4'b0001, 1'b0, 8'd0,   4'b0001, 8'd0, 9'd256};
    vec[1]  = '{4'b1111, 1'b0, 8'd0,   4'b0010, 8'd1, 9'd255};
    vec[2]  = '{4'b1111, 1'b0, 8'd0,   4'b0100, 8'd2, 9'd254};
    vec[3]  = '{4'b1111, 1'b0, 8'd0,   4'b1000, 8'd3, 9'd253};
    vec[4]  = '{4'b1111, 1'b0, 8'd0,   4'b0001, 8'd4, 9'd252};
    vec[5]  = '{4'b1111, 1'b0, 8'd0,   4'b0010, 8'd5, 9'd251};
    vec[6]  = '{4'b1010, 1'b0, 8'd0,   4'b1000, 8'd6, 9'd250};
    vec[7]  = '{4'b0011, 1'b0, 8'd0,   4'b0001, 8'd7, 9'd249};
    vec[8]  = '{4'b0000, 1'b1, 8'd200, 4'b0000, 8'd0, 9'd248};
    vec[9]  = '{4'b0100, 1'b1, 8'd201, 4'b0100, 8'd8, 9'd249};
    vec[10] = '{4'b0000, 1'b0, 8'd0,   4'b0000, 8'd0, 9'd249};

    #2;
    chk_reset_vals("reset");
    alloc_req_i = 4'b0001;
    repeat (3) @(negedge clk);

    // Init: no grants for NB cycles, count climbs 0..255.
    rst_n = 1'b1;
    #2;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) cyc(4'b0001, 1'b0, '0);
      chk("init_nogrant", int'(alloc_gnt_o), 0);
      chk("init_cnt", int'(free_cnt_o), k);
    end

    for (int i = 0; i < 11; i++) begin
      cyc(vec[i].req, vec[i].fv, vec[i].fidx);
      if (i == 0) chk("init_done", int'(init_done_o), 1);
      chk($sformatf("vec%0d_gnt", i), int'(alloc_gnt_o), int'(vec[i].gnt));
      chk($sformatf("vec%0d_idx", i), int'(alloc_block_idx_o), int'(vec[i].idx));
      chk($sformatf("vec%0d_cnt", i), int'(free_cnt_o), int'(vec[i].cnt));
    end

    // Exhaust: remaining 249 entries are 9..255 then the refilled 200, 201.
    for (int i = 0; i < 249; i++) begin
      cyc(4'b0001, 1'b0, '0);
      exp_idx = (9 + i <= 255) ? 9 + i : ((9 + i == 256) ? 200 : 201);
      chk("exh_gnt", int'(alloc_gnt_o), 1);
      chk("exh_idx", int'(alloc_block_idx_o), exp_idx);
      chk("exh_cnt", int'(free_cnt_o), 249 - i);
    end
    cyc(4'b0001, 1'b0, '0);
    chk("empty_flag", int'(empty_o), 1);
    chk("empty_stall", int'(alloc_gnt_o), 0);

    // No bypass: the freed block is grantable only from the next cycle.
    cyc(4'b0001, 1'b1, 8'd17);
    chk("bypass_gnt", int'(alloc_gnt_o), 0);
    cyc(4'b0001, 1'b0, '0);
    chk("refill_gnt", int'(alloc_gnt_o), 1);
    chk("refill_idx", int'(alloc_block_idx_o), 17);
    chk("refill_cnt", int'(free_cnt_o), 1);

    // Simultaneous grant and free with one block in the pool.
    cyc(4'b0000, 1'b1, 8'd42);
    chk("sim_pre_cnt", int'(free_cnt_o), 0);
    cyc(4'b0001, 1'b1, 8'd99);
    chk("sim_cnt", int'(free_cnt_o), 1);
    chk("sim_idx", int'(alloc_block_idx_o), 42);
    cyc(4'b0001, 1'b0, '0);
    chk("sim_cnt_after", int'(free_cnt_o), 1);
    chk("sim_next_idx", int'(alloc_block_idx_o), 99);
    cyc(4'b0000, 1'b0, '0);
    chk("sim_drained", int'(free_cnt_o), 0);

    // Fill the pool with 0..255, then attempt a double free.
    for (int i = 0; i < NB; i++) cyc(4'b0000, 1'b1, AW'(i));
    cyc(4'b0000, 1'b1, 8'd77);
    chk("ovf_pre_cnt", int'(free_cnt_o), 256);
    chk("ovf_pre_err", int'(err_o), 0);
    cyc(4'b0001, 1'b0, '0);
    chk("ovf_err", int'(err_o), 1);
    chk("ovf_cnt", int'(free_cnt_o), 256);
    chk("ovf_head", int'(alloc_block_idx_o), 0);
    for (int i = 1; i < 10; i++) begin
      cyc(4'b0001, 1'b0, '0);
      chk("post_ovf_idx", int'(alloc_block_idx_o), i);
      chk("err_sticky", int'(err_o), 1);
    end

    // Mid-run reset, then re-init with a stray free in INIT.
    @(negedge clk);
    rst_n = 1'b0;
    alloc_req_i = 4'b1111;
    #2;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) cyc(4'b1111, (k == 5), 8'd3);
      chk("reinit_nogrant", int'(alloc_gnt_o), 0);
      chk("reinit_cnt", int'(free_cnt_o), k);
      if (k == 5) chk("reinit_err_pre", int'(err_o), 0);
      if (k == 6) chk("reinit_err", int'(err_o), 1);
    end
    cyc(4'b1111, 1'b0, '0);
    chk("reinit_gnt", int'(alloc_gnt_o), 1);
    chk("reinit_idx", int'(alloc_block_idx_o), 0);
    chk("reinit_cnt_full", int'(free_cnt_o), 256);
    cyc(4'b0000, 1'b0, '0);
    chk("reinit_err_hold", int'(err_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
